// File: rtl/countdown_timer.sv
// Loadable BCD HH:MM:SS countdown timer with expiry flag and load validation.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN to reload at zero instead of stopping.
module countdown_timer #(
    parameter int unsigned HR_MAX = 23
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] set_msb_hr,
    input  logic [3:0] set_lsb_hr,
    input  logic [3:0] set_msb_min,
    input  logic [3:0] set_lsb_min,
    input  logic [3:0] set_msb_sec,
    input  logic [3:0] set_lsb_sec,
    output logic [3:0] msb_hr,
    output logic [3:0] lsb_hr,
    output logic [3:0] msb_min,
    output logic [3:0] lsb_min,
    output logic [3:0] msb_sec,
    output logic [3:0] lsb_sec,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state, state_nx;
    logic [23:0] cnt, cnt_nx, reload, reload_nx, cnt_dec, set_val;
    logic [7:0]  hr_val;
    logic        done_nx, err_nx, load_ok, is_zero, at_one;

    // Subtract one second; digit order is {hr10, hr1, min10, min1, sec10, sec1}.
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign set_val = {set_msb_hr, set_lsb_hr, set_msb_min, set_lsb_min, set_msb_sec, set_lsb_sec};
    assign hr_val  = {4'd0, set_msb_hr} * 8'd10 + {4'd0, set_lsb_hr};
    assign load_ok = (set_lsb_sec <= 4'd9) && (set_msb_sec <= 4'd5) &&
                     (set_lsb_min <= 4'd9) && (set_msb_min <= 4'd5) &&
                     (set_lsb_hr  <= 4'd9) && (hr_val <= HR_MAX[7:0]);
    assign is_zero = (cnt == 24'h000000);
    assign at_one  = (cnt == 24'h000001);
    assign cnt_dec = bcd_dec(cnt);

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            reload   <= '0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            reload   <= reload_nx;
            done     <= done_nx;
            load_err <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        reload_nx = reload;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        if (load) begin
            if (load_ok) begin
                cnt_nx    = set_val;
                reload_nx = set_val;
                state_nx  = IDLE;
            end else begin
                err_nx = 1'b1;
            end
        end else begin
            case (state)
                IDLE: if (!pause && start && !is_zero) state_nx = RUN;
                RUN: begin
                    if (pause) begin
                        state_nx = PAUSE;
                    end else if (is_zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        // Zero was shown for one cycle after done; now restart the period.
                        cnt_nx = reload;
`else
                        state_nx = DONE;
`endif
                    end else if (at_one) begin
                        cnt_nx  = '0;
                        done_nx = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (reload == 24'h000000) state_nx = DONE;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                PAUSE: if (!pause && start && !is_zero) state_nx = RUN;
                default: ;
            endcase
        end
    end

    assign {msb_hr, lsb_hr, msb_min, lsb_min, msb_sec, lsb_sec} = cnt;
    assign running = (state == RUN);
    assign expired = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (HR_MAX = 23).
module tb_countdown_timer;

    logic       clk_1Hz = 1'b0;
    logic       reset, load, start, pause;
    logic [3:0] set_msb_hr, set_lsb_hr, set_msb_min, set_lsb_min, set_msb_sec, set_lsb_sec;
    logic [3:0] msb_hr, lsb_hr, msb_min, lsb_min, msb_sec, lsb_sec;
    logic       running, expired, done, load_err;
    int         n_chk = 0;
    int         n_err = 0;

    countdown_timer #(.HR_MAX(23)) dut (
        .clk_1Hz(clk_1Hz), .reset(reset), .load(load), .start(start), .pause(pause),
        .set_msb_hr(set_msb_hr), .set_lsb_hr(set_lsb_hr),
        .set_msb_min(set_msb_min), .set_lsb_min(set_lsb_min),
        .set_msb_sec(set_msb_sec), .set_lsb_sec(set_lsb_sec),
        .msb_hr(msb_hr), .lsb_hr(lsb_hr), .msb_min(msb_min), .lsb_min(lsb_min),
        .msb_sec(msb_sec), .lsb_sec(lsb_sec),
        .running(running), .expired(expired), .done(done), .load_err(load_err)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares digits plus {running, expired, done, load_err} in one go.
    task automatic chk_all(input string tag, input logic [23:0] val, input logic [3:0] flags);
        chk({tag, " value"}, {8'd0, msb_hr, lsb_hr, msb_min, lsb_min, msb_sec, lsb_sec}, {8'd0, val});
        chk({tag, " flags"}, {28'd0, running, expired, done, load_err}, {28'd0, flags});
    endtask

    task automatic tick();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic do_load(input logic [23:0] v);
        {set_msb_hr, set_lsb_hr, set_msb_min, set_lsb_min, set_msb_sec, set_lsb_sec} = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
        {set_msb_hr, set_lsb_hr, set_msb_min, set_lsb_min, set_msb_sec, set_lsb_sec} = '0;
        #2;
        chk_all("reset", 24'h000000, 4'b0000);
        #1 reset = 1'b0;

        // Count from 3 s to zero
        do_load(24'h000003);
        chk_all("load3", 24'h000003, 4'b0000);
        do_start();
        chk_all("start3", 24'h000003, 4'b1000);
        tick(); chk_all("dec2", 24'h000002, 4'b1000);
        tick(); chk_all("dec1", 24'h000001, 4'b1000);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        tick(); chk_all("zero", 24'h000000, 4'b1010);
        tick(); chk_all("reload", 24'h000003, 4'b1000);
        tick(); chk_all("rdec2", 24'h000002, 4'b1000);
`else
        tick(); chk_all("zero", 24'h000000, 4'b0110);
        tick(); chk_all("expired", 24'h000000, 4'b0100);
        do_start();
        chk_all("start_in_done", 24'h000000, 4'b0100);
`endif

        // Borrow across digit groups
        do_load(24'h100000);
        chk_all("load10h", 24'h100000, 4'b0000);
        do_start();
        tick(); chk_all("borrow_hr", 24'h095959, 4'b1000);
        do_load(24'h000100);
        do_start();
        tick(); chk_all("borrow_min", 24'h000059, 4'b1000);

        // Pause / resume
        do_load(24'h000500);
        do_start();
        pause = 1'b1;
        tick(); chk_all("pause1", 24'h000500, 4'b0000);
        tick(); tick(); chk_all("pause3", 24'h000500, 4'b0000);
        pause = 1'b0;
        do_start();
        chk_all("resume", 24'h000500, 4'b1000);
        tick(); chk_all("resume_dec", 24'h000459, 4'b1000);
        start = 1'b1; pause = 1'b1;
        tick(); chk_all("start_pause", 24'h000459, 4'b0000);
        start = 1'b0; pause = 1'b0;
        tick(); chk_all("paused_hold", 24'h000459, 4'b0000);

        // Load validation
        do_load(24'h240000); chk_all("bad_hr", 24'h000459, 4'b0001);
        tick();              chk_all("err_clear", 24'h000459, 4'b0000);
        do_load(24'h006000); chk_all("bad_min", 24'h000459, 4'b0001);
        do_load(24'h00000A); chk_all("bad_sec", 24'h000459, 4'b0001);
        do_load(24'h235959); chk_all("max_ok", 24'h235959, 4'b0000);

        // Start at zero is ignored
        do_load(24'h000000);
        do_start();
        chk_all("start_zero", 24'h000000, 4'b0000);

        // Asynchronous reset mid-count
        do_load(24'h012345);
        do_start();
        chk_all("run12345", 24'h012345, 4'b1000);
        #1 reset = 1'b1;
        #1 chk_all("async_rst", 24'h000000, 4'b0000);
        reset = 1'b0;
        do_start();
        chk_all("start_after_rst", 24'h000000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
